// File: rtl/chunked_seq_adder_if.sv
// Request/result bundle for chunked_seq_adder; Sub exists only with CHUNKED_SEQ_ADDER_ADDSUB_EN.
// master drives the operands and Start, slave (the adder) drives the results.
interface chunked_seq_adder_if #(
   parameter int WIDTH = 16
) ();
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
`ifdef CHUNKED_SEQ_ADDER_ADDSUB_EN
   logic             Sub;
`endif
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             Ovf;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, A, B, Cin,
`ifdef CHUNKED_SEQ_ADDER_ADDSUB_EN
      output Sub,
`endif
      input  S, Cout, Ovf, Busy, Done
   );

   modport slave (
      input  Start, A, B, Cin,
`ifdef CHUNKED_SEQ_ADDER_ADDSUB_EN
      input  Sub,
`endif
      output S, Cout, Ovf, Busy, Done
   );
endinterface

// File: rtl/chunked_seq_adder.sv
// Sequential A+B+Cin, CHUNK bits per cycle; subtract option under CHUNKED_SEQ_ADDER_ADDSUB_EN.
// Done pulses N+1 cycles after accept; Start is ignored (not queued) while Busy.
module chunked_seq_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                Clk,
   input logic                Reset,
   chunked_seq_adder_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] wa, wb, ws;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             a_msb, b_msb;
   logic [WIDTH-1:0] s_q;
   logic             cout_q, ovf_q;

   logic             accept, last;
   logic [CHUNK:0]   slice;
   logic [WIDTH-1:0] slice_ext, ws_nxt;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   always_comb begin
      b_eff   = bus.B;
      cin_eff = bus.Cin;
`ifdef CHUNKED_SEQ_ADDER_ADDSUB_EN
      // A - B == A + ~B + 1, so Cout high means no borrow
      if (bus.Sub) begin
         b_eff   = ~bus.B;
         cin_eff = 1'b1;
      end
`endif
   end

   assign slice     = {1'b0, wa[CHUNK-1:0]} + {1'b0, wb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
   assign slice_ext = WIDTH'(slice[CHUNK-1:0]);
   // Each slice enters at the top; after N slices the first one sits at bit 0
   assign ws_nxt    = (ws >> CHUNK) | (slice_ext << (WIDTH - CHUNK));
   assign last      = (cnt == LAST);

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            accept    = bus.Start;
            state_nxt = bus.Start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wa     <= '0;
         wb     <= '0;
         ws     <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         wa    <= bus.A;
         wb    <= b_eff;
         ws    <= '0;
         carry <= cin_eff;
         cnt   <= '0;
         a_msb <= bus.A[WIDTH-1];
         b_msb <= b_eff[WIDTH-1];
      end else if (state == RUN) begin
         wa    <= wa >> CHUNK;
         wb    <= wb >> CHUNK;
         ws    <= ws_nxt;
         carry <= slice[CHUNK];
         cnt   <= cnt + CW'(1);
         if (last) begin
            s_q    <= ws_nxt;
            cout_q <= slice[CHUNK];
            ovf_q  <= (a_msb == b_msb) && (ws_nxt[WIDTH-1] != a_msb);
         end
      end
   end

   assign bus.S    = s_q;
   assign bus.Cout = cout_q;
   assign bus.Ovf  = ovf_q;
   assign bus.Busy = (state == RUN);
   assign bus.Done = (state == DONE);
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed checks of chunked_seq_adder: 16/4 add instance plus an 8/8 single-slice instance.
// Subtract vectors run only when CHUNKED_SEQ_ADDER_ADDSUB_EN is defined.
module tb_chunked_seq_adder;
   logic Clk;
   logic Reset;
   int   checks;
   int   errors;

   chunked_seq_adder_if #(.WIDTH(16)) bus16 ();
   chunked_seq_adder_if #(.WIDTH(8))  bus8 ();

   chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.Clk(Clk), .Reset(Reset), .bus(bus16.slave));
   chunked_seq_adder #(.WIDTH(8),  .CHUNK(8)) dut8  (.Clk(Clk), .Reset(Reset), .bus(bus8.slave));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      bus16.A   = a;
      bus16.B   = b;
      bus16.Cin = cin;
`ifdef CHUNKED_SEQ_ADDER_ADDSUB_EN
      bus16.Sub = sub;
`else
      if (sub) $display("note: sub request ignored in add-only build");
`endif
   endtask

   // One full operation on the 16/4 instance: 4 busy cycles, then a Done cycle
   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] prev_s,
                        input logic [15:0] es, input logic ec, input logic eo);
      set16(a, b, cin, sub);
      bus16.Start = 1'b1;
      step();
      bus16.Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy"}, bus16.Busy, 1);
         check({tag, "_nodone"}, bus16.Done, 0);
         if (i == 2) check({tag, "_shold"}, bus16.S, prev_s);
         bus16.A = 16'hFFFF;
         bus16.B = 16'hFFFF;
         step();
      end
      check({tag, "_done"}, bus16.Done, 1);
      check({tag, "_idlebusy"}, bus16.Busy, 0);
      check({tag, "_s"}, bus16.S, es);
      check({tag, "_cout"}, bus16.Cout, ec);
      check({tag, "_ovf"}, bus16.Ovf, eo);
      step();
      check({tag, "_donepulse"}, bus16.Done, 0);
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      Reset = 1'b1;
      bus16.Start = 1'b0;
      bus8.Start  = 1'b0;
      set16(16'h0, 16'h0, 1'b0, 1'b0);
      bus8.A = 8'h0;
      bus8.B = 8'h0;
      bus8.Cin = 1'b0;
`ifdef CHUNKED_SEQ_ADDER_ADDSUB_EN
      bus8.Sub = 1'b0;
`endif
      step();
      step();
      check("rst_s", bus16.S, 0);
      check("rst_cout", bus16.Cout, 0);
      check("rst_ovf", bus16.Ovf, 0);
      check("rst_busy", bus16.Busy, 0);
      check("rst_done", bus16.Done, 0);
      Reset = 1'b0;

      run16("add_basic", 16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h0000, 16'h00FF, 1'b0, 1'b0);
      run16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0);
      run16("add_ovf",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b1);
      run16("add_negovf",16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b1);

      // Start held high: one result every 5 cycles, operands scrambled while running
      set16(16'h1234, 16'h1111, 1'b0, 1'b0);
      bus16.Start = 1'b1;
      for (int r = 0; r < 3; r++) begin
         n = 0;
         do begin
            step();
            n++;
            if (bus16.Busy) begin
               bus16.A = 16'hA5A5;
               bus16.B = 16'h5A5A;
            end else begin
               bus16.A = 16'h1234;
               bus16.B = 16'h1111;
            end
         end while (!bus16.Done && n < 12);
         check("b2b_period", n, 5);
         check("b2b_s", bus16.S, 16'h2345);
      end
      bus16.Start = 1'b0;
      step();
      check("b2b_stop", bus16.Busy, 0);

      // Reset during the second RUN cycle discards the operation
      set16(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      bus16.Start = 1'b1;
      step();
      bus16.Start = 1'b0;
      step();
      check("midrst_running", bus16.Busy, 1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("midrst_s", bus16.S, 0);
      check("midrst_busy", bus16.Busy, 0);
      check("midrst_done", bus16.Done, 0);
      step();
      check("midrst_idle", bus16.Done, 0);
      run16("after_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h0000, 16'h5556, 1'b0, 1'b0);

      // Reset beats a simultaneous Start
      bus16.Start = 1'b1;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      bus16.Start = 1'b0;
      check("rst_vs_start", bus16.Busy, 0);
      step();
      check("rst_vs_start_nodone", bus16.Done, 0);

`ifdef CHUNKED_SEQ_ADDER_ADDSUB_EN
      run16("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h0000, 16'hFFFE, 1'b0, 1'b0);
      run16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 16'h7FFF, 1'b1, 1'b1);
`endif

      // Single-slice instance: Done two cycles after accept
      bus8.A = 8'h80;
      bus8.B = 8'h80;
      bus8.Start = 1'b1;
      step();
      bus8.Start = 1'b0;
      check("n1_busy", bus8.Busy, 1);
      check("n1_nodone", bus8.Done, 0);
      step();
      check("n1_done", bus8.Done, 1);
      check("n1_s", bus8.S, 8'h00);
      check("n1_cout", bus8.Cout, 1);
      check("n1_ovf", bus8.Ovf, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/chunked_seq_adder.md
# chunked_seq_adder

Parametrised multi-cycle adder computing S = A + B + Cin over WIDTH bits, CHUNK bits per clock, through an explicit start/done handshake. It generalises the combinational 16-bit ripple adder into a sequential, width-configurable datapath. It sits between a register-file or switch-input stage and a result register/display stage. It trades latency for a short carry chain: the critical path is one CHUNK-bit ripple.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK cycles per operation (N ≥ 1).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; accepted only in IDLE or DONE.
- A  in  WIDTH  operand A, sampled on accept.
- B  in  WIDTH  operand B, sampled on accept.
- Cin  in  1  carry-in, sampled on accept.
- Sub  in  1  present only with ADDSUB_EN; sampled on accept; 1 = subtract.
- S  out  WIDTH  result register.
- Cout  out  1  carry out of bit WIDTH-1.
- Ovf  out  1  signed (two's-complement) overflow.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse when S/Cout/Ovf update.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: accepting Start latches A, B and Cin into working shift registers. It loads the carry register with Cin, clears the slice counter and moves to RUN.
- RUN: each cycle adds the low CHUNK bits of the working A and B plus the carry register. The CHUNK-bit sum shifts into the top of the working sum register. The carry register takes the slice carry-out. The working A and B shift right by CHUNK. The counter increments.
- When the counter reaches N-1, the last slice is processed that cycle and the FSM moves to DONE.
- On the RUN→DONE edge, S takes the full working sum and Cout takes the final carry. Ovf is (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]), where B' is the operand actually added.
- DONE: lasts one cycle with Done = 1. Start in DONE is accepted exactly as in IDLE (RUN next cycle); otherwise the FSM goes to IDLE.
- Start in RUN is ignored and is not queued.
- S, Cout and Ovf hold their last values until the next completion. They do not change during a subsequent RUN.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset values: S = 0, Cout = 0, Ovf = 0, Busy = 0, Done = 0, FSM = IDLE, working registers and counter = 0.
- Latency: Start accepted at edge t gives Busy = 1 for edges t+1 … t+N, and Done = 1 plus valid results after edge t+N+1.
- Back-to-back throughput: one result per N+1 cycles when Start is held high.
- Reset mid-RUN: the next edge returns to IDLE with all outputs at reset values; the partial result is discarded.
- Reset and Start in the same cycle: Reset wins.
- CHUNK = WIDTH (N = 1): RUN lasts one cycle, so Done comes 2 cycles after accept.

## Configuration
- Macro: CHUNKED_SEQ_ADDER_ADDSUB_EN.
- Defined:
  - The Sub port exists.
  - On accept with Sub = 1, the working B is loaded with ~B and the carry register with 1; Cin is ignored.
  - Cout = 1 means no borrow.
  - Ovf uses the inverted B MSB.
- Undefined: no Sub port; the block is add-only.

## Test plan
- WIDTH=16, CHUNK=4, A=0x00F0, B=0x000F, Cin=0, Start pulse → Busy for 4 cycles, Done on cycle 5, S=0x00FF, Cout=0, Ovf=0.
- A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1, Ovf=0; then A=0x7FFF, B=0x0000, Cin=1 → S=0x8000, Cout=0, Ovf=1.
- Start held high with A=0x1234, B=0x1111 → Done every 5 cycles, S=0x2345 each time; operand changes during RUN have no effect on the current result.
- Reset asserted on the 2nd RUN cycle → all outputs 0 and FSM in IDLE the next cycle; a new Start then completes normally.
- ADDSUB_EN defined, Sub=1, A=0x0005, B=0x0007 → S=0xFFFE, Cout=0; A=0x8000, B=0x0001 → S=0x7FFF, Ovf=1.
- WIDTH=8, CHUNK=8, A=0x80, B=0x80 → Done 2 cycles after accept, S=0x00, Cout=1, Ovf=1.
